// File: rtl/sort_result_reader.sv
// Captures a sorter's parallel result on the rising edge of done, streams it out
// one element per valid/ready beat and reports whether the frame was in order.
module sort_result_reader #(
  parameter int N          = 6,
  parameter int WIDTH      = 8,
  parameter int DESCENDING = 0,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [WIDTH-1:0] data_sorted [N],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_index,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_sorted,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_t;

  state_t           state_reg;
  logic             done_d_reg;
  logic [IW-1:0]    idx_reg;
  logic             err_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] frame_buf [N];

  logic             rise;
  logic             capture;
  logic             beat;
  logic             last_beat;
  logic             order_bad;
  logic [WIDTH-1:0] cur;
  logic [IW-1:0]    idx_next;

  assign rise      = done & ~done_d_reg;
  assign capture   = (state_reg == IDLE) & rise;
  assign beat      = (state_reg == STREAM) & out_valid & out_ready;
  assign cur       = frame_buf[idx_reg];
  assign idx_next  = IW'(idx_reg + 1'b1);
  assign last_beat = (idx_reg == IW'(N - 1));

  // Element 0 has no predecessor; equal neighbours are always acceptable.
  assign order_bad = (idx_reg != '0) &&
                     ((DESCENDING != 0) ? (cur > prev_reg) : (cur < prev_reg));

  // Frame storage needs no reset: it is only read after a capture has filled it.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        frame_buf[i] <= data_sorted[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      done_d_reg   <= 1'b0;
      idx_reg      <= '0;
      err_reg      <= 1'b0;
      prev_reg     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_sorted <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done_d_reg   <= done;
      frame_done   <= 1'b0;
      frame_sorted <= 1'b0;
      if (rise && (state_reg != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (rise) begin
            idx_reg   <= '0;
            err_reg   <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= data_sorted[0];
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (beat) begin
            prev_reg <= cur;
            if (order_bad) begin
              err_reg <= 1'b1;
            end
            if (last_beat) begin
              // Final compare is folded directly into the status pulse.
              out_valid    <= 1'b0;
              out_last     <= 1'b0;
              frame_done   <= 1'b1;
              frame_sorted <= ~(err_reg | order_bad);
              state_reg    <= REPORT;
            end else begin
              idx_reg   <= idx_next;
              out_data  <= frame_buf[idx_next];
              out_index <= idx_next;
              out_last  <= (idx_next == IW'(N - 1));
            end
          end
        end
        REPORT: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
